// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl : data-memory line controller
//
// Purpose
//   Serves 128-bit line reads for the data cache with a fixed, parameterised
//   latency, and accepts line write-backs on any cycle. The backing store is a
//   2**ADDR_BITS x 128-bit array. Only the low ADDR_BITS of a line index are
//   used, so indices that differ only in their upper bits alias.
//
// Parameters
//   LINE_BITS  : width of the line index on the request and write-back ports
//   ADDR_BITS  : log2 of the array depth in lines
//   RD_LATENCY : cycles from request acceptance to the valid cycle (1..15)
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   synchronous active-high reset
//   Dc_mem_req     in   line-read request (sampled only in IDLE)
//   Dc_mem_addr    in   line index to read
//   MEM_data_line  out  captured read line, word n in bits [32n+31:32n]
//   MEM_mem_valid  out  one-cycle pulse marking MEM_data_line as valid
//   Dc_wb_we       in   write-back strobe
//   Dc_wb_addr     in   write-back line index
//   Dc_wb_wline    in   write-back line data
//   Dm_rd_cnt      out  completed-read count
//   Dm_wb_cnt      out  accepted write-back count
//   Dm_busy        out  high while a read is in flight (BUSY or RESP)
//
// Configuration
//   DMEM_STATS_EN  : when defined, Dm_rd_cnt / Dm_wb_cnt are live 32-bit
//                    wrapping counters; otherwise both ports are tied to 0
//                    and no counter flops exist.
// -----------------------------------------------------------------------------
module dmem_ctrl #(
  parameter int LINE_BITS  = 16,
  parameter int ADDR_BITS  = 12,
  parameter int RD_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Dc_mem_req,
  input  logic [LINE_BITS-1:0] Dc_mem_addr,
  output logic [127:0]         MEM_data_line,
  output logic                 MEM_mem_valid,
  input  logic                 Dc_wb_we,
  input  logic [LINE_BITS-1:0] Dc_wb_addr,
  input  logic [127:0]         Dc_wb_wline,
  output logic [31:0]          Dm_rd_cnt,
  output logic [31:0]          Dm_wb_cnt,
  output logic                 Dm_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int         DEPTH  = 1 << ADDR_BITS;
  localparam logic [3:0] LAT_M1 = 4'(RD_LATENCY - 1);

  // Backing store: no reset so it maps onto block RAM.
  logic [127:0] mem_array [0:DEPTH-1];

  state_t               state_q, state_d;
  logic [3:0]           cnt_q,   cnt_d;
  logic [ADDR_BITS-1:0] addr_q,  addr_d;
  logic [127:0]         line_q,  line_d;
  logic                 valid_q, valid_d;
  logic                 busy_q,  busy_d;

  logic [ADDR_BITS-1:0] rd_idx;
  logic [ADDR_BITS-1:0] wb_idx;
  logic                 wb_en;
  logic                 capture;

  assign wb_idx = Dc_wb_addr[ADDR_BITS-1:0];
  // Write-backs presented while reset is held are dropped.
  assign wb_en  = Dc_wb_we & ~rst;

  // Upper index bits only select aliases and are intentionally discarded.
  generate
    if (LINE_BITS > ADDR_BITS) begin : g_alias_bits
      logic unused_idx_bits;
      assign unused_idx_bits = ^{Dc_mem_addr[LINE_BITS-1:ADDR_BITS],
                                 Dc_wb_addr[LINE_BITS-1:ADDR_BITS]};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // The countdown is loaded with RD_LATENCY-1 at acceptance and the line is
  // captured on the edge at which the counter value being written reaches 0.
  // That places the valid cycle exactly RD_LATENCY cycles after the request
  // cycle; with RD_LATENCY=1 the capture happens on the acceptance edge and
  // BUSY is skipped entirely.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rd_idx  = addr_q;
    capture = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Dc_mem_req) begin
          addr_d = Dc_mem_addr[ADDR_BITS-1:0];
          rd_idx = Dc_mem_addr[ADDR_BITS-1:0];
          cnt_d  = LAT_M1;
          if (LAT_M1 == 4'd0) begin
            capture = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_d == 4'd0) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        // Requests seen here are ignored; the next acceptance is from IDLE.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A write-back landing on the captured line in the same edge wins over
    // the stale array contents.
    line_d = line_q;
    if (capture) begin
      if (wb_en && (wb_idx == rd_idx)) begin
        line_d = Dc_wb_wline;
      end else begin
        line_d = mem_array[rd_idx];
      end
    end

    valid_d = (state_d == ST_RESP);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      line_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wb_en) begin
      mem_array[wb_idx] <= Dc_wb_wline;
    end
  end

  assign MEM_data_line = line_q;
  assign MEM_mem_valid = valid_q;
  assign Dm_busy       = busy_q;

  // ---------------------------------------------------------------------------
  // Statistics counters.
  // ---------------------------------------------------------------------------
`ifdef DMEM_STATS_EN
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wb_cnt_q, wb_cnt_d;

  // valid_q is high exactly in the RESP cycle, so it marks a completed read.
  always_comb begin
    rd_cnt_d = rd_cnt_q + {31'd0, valid_q};
    wb_cnt_d = wb_cnt_q + {31'd0, Dc_wb_we};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= 32'd0;
      wb_cnt_q <= 32'd0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wb_cnt_q <= wb_cnt_d;
    end
  end

  assign Dm_rd_cnt = rd_cnt_q;
  assign Dm_wb_cnt = wb_cnt_q;
`else
  assign Dm_rd_cnt = 32'd0;
  assign Dm_wb_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_ctrl : self-checking bench for dmem_ctrl (RD_LATENCY = 4)
//
// A cycle-scheduled reference model (array image plus "response due in cycle
// N" bookkeeping) predicts every output each cycle; a negedge process
// compares. Directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_dmem_ctrl;

  localparam int LB  = 16;
  localparam int AB  = 12;
  localparam int LAT = 4;
`ifdef DMEM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          Dc_mem_req = 1'b0;
  logic [LB-1:0] Dc_mem_addr = '0;
  logic [127:0]  MEM_data_line;
  logic          MEM_mem_valid;
  logic          Dc_wb_we = 1'b0;
  logic [LB-1:0] Dc_wb_addr = '0;
  logic [127:0]  Dc_wb_wline = '0;
  logic [31:0]   Dm_rd_cnt;
  logic [31:0]   Dm_wb_cnt;
  logic          Dm_busy;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  dmem_ctrl #(
    .LINE_BITS (LB),
    .ADDR_BITS (AB),
    .RD_LATENCY(LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .Dc_mem_req   (Dc_mem_req),
    .Dc_mem_addr  (Dc_mem_addr),
    .MEM_data_line(MEM_data_line),
    .MEM_mem_valid(MEM_mem_valid),
    .Dc_wb_we     (Dc_wb_we),
    .Dc_wb_addr   (Dc_wb_addr),
    .Dc_wb_wline  (Dc_wb_wline),
    .Dm_rd_cnt    (Dm_rd_cnt),
    .Dm_wb_cnt    (Dm_wb_cnt),
    .Dm_busy      (Dm_busy)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: a read accepted at the end of cycle c is owed in cycle
  // c+LAT with whatever the line holds after the edge ending cycle c+LAT-1.
  // ---------------------------------------------------------------------------
  logic [127:0]  mem_m [0:(1<<AB)-1];
  int            cyc_m = 0;
  logic          pend_m = 1'b0;
  int            resp_at_m = 0;
  logic [AB-1:0] ra_m = '0;

  logic [127:0]  exp_data = '0;
  logic          exp_valid = 1'b0;
  logic          exp_busy = 1'b0;
  logic [31:0]   exp_rd = '0;
  logic [31:0]   exp_wb = '0;

  logic          m_idle, m_accept, m_pend_n, m_capture;
  int            m_resp_n;
  logic [AB-1:0] m_ra, m_wa;

  always_comb begin
    m_idle    = !pend_m || (cyc_m > resp_at_m);
    m_accept  = !rst && Dc_mem_req && m_idle;
    m_ra      = m_accept ? Dc_mem_addr[AB-1:0] : ra_m;
    m_resp_n  = m_accept ? (cyc_m + LAT) : resp_at_m;
    m_pend_n  = pend_m || m_accept;
    m_capture = !rst && m_pend_n && (cyc_m == m_resp_n - 1);
    m_wa      = Dc_wb_addr[AB-1:0];
  end

  always @(posedge clk) begin
    cyc_m <= cyc_m + 1;
    if (rst) begin
      pend_m    <= 1'b0;
      exp_data  <= '0;
      exp_valid <= 1'b0;
      exp_busy  <= 1'b0;
      exp_rd    <= '0;
      exp_wb    <= '0;
    end else begin
      if (Dc_wb_we) begin
        mem_m[m_wa] <= Dc_wb_wline;
        exp_wb      <= exp_wb + 32'd1;
      end
      if (exp_valid) exp_rd <= exp_rd + 32'd1;
      if (m_accept) begin
        pend_m    <= 1'b1;
        resp_at_m <= cyc_m + LAT;
        ra_m      <= Dc_mem_addr[AB-1:0];
      end
      if (m_capture) begin
        exp_data <= (Dc_wb_we && (m_wa == m_ra)) ? Dc_wb_wline : mem_m[m_ra];
      end
      exp_valid <= m_pend_n && (m_resp_n == cyc_m + 1);
      exp_busy  <= m_pend_n && (cyc_m + 1 <= m_resp_n);
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", {127'd0, MEM_mem_valid}, {127'd0, exp_valid});
      check("busy",  {127'd0, Dm_busy},       {127'd0, exp_busy});
      check("data",  MEM_data_line,           exp_data);
      check("rd_cnt", {96'd0, Dm_rd_cnt}, {96'd0, (STATS ? exp_rd : 32'd0)});
      check("wb_cnt", {96'd0, Dm_wb_cnt}, {96'd0, (STATS ? exp_wb : 32'd0)});
      if (MEM_mem_valid)
        $display("read response t=%0t data=%h rd_cnt=%0d", $time, MEM_data_line, Dm_rd_cnt);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wb(input logic [LB-1:0] a, input logic [127:0] d);
    Dc_wb_we = 1'b1; Dc_wb_addr = a; Dc_wb_wline = d;
    tick();
    Dc_wb_we = 1'b0;
    $display("write-back addr=%h data=%h", a, d);
  endtask

  // Request in the current cycle (cycle 0); valid must appear only in LAT.
  task automatic read_line(input logic [LB-1:0] a, input logic [127:0] exp_line, input string nm);
    Dc_mem_req = 1'b1; Dc_mem_addr = a;
    tick();
    Dc_mem_req = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      check({nm, " valid"}, {127'd0, MEM_mem_valid}, {127'd0, (k == LAT)});
      if (k == LAT) check({nm, " data"}, MEM_data_line, exp_line);
      tick();
    end
  endtask

  localparam logic [127:0] LIT1 = 128'h4444_3333_2222_1111;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset valid", {127'd0, MEM_mem_valid}, 128'd0);
    check("reset data", MEM_data_line, 128'd0);
    check("reset busy", {127'd0, Dm_busy}, 128'd0);

    // Basic read of a preloaded line.
    wb(16'h0010, LIT1);
    tick();
    read_line(16'h0010, LIT1, "basic");
    check("basic rd_cnt", {96'd0, Dm_rd_cnt}, STATS ? 128'd1 : 128'd0);

    // Write in cycle 0, read in cycle 1.
    pulse_reset();
    wb(16'h0020, 128'hA);
    read_line(16'h0020, 128'hA, "wb_then_rd");
    check("wb_then_rd wb_cnt", {96'd0, Dm_wb_cnt}, STATS ? 128'd1 : 128'd0);
    check("wb_then_rd rd_cnt", {96'd0, Dm_rd_cnt}, STATS ? 128'd1 : 128'd0);

    // Forwarding: write-back on the capture edge.
    wb(16'h0030, 128'h0);
    tick();
    Dc_mem_req = 1'b1; Dc_mem_addr = 16'h0030;
    tick();
    Dc_mem_req = 1'b0;
    tick();
    tick();
    wb(16'h0030, 128'hBEEF);
    check("fwd valid", {127'd0, MEM_mem_valid}, 128'd1);
    check("fwd data", MEM_data_line, 128'hBEEF);
    tick(); tick();

    // Back-to-back with request held high.
    wb(16'h0001, 128'h0101_0101);
    wb(16'h0002, 128'h0202_0202);
    tick();
    Dc_mem_req = 1'b1; Dc_mem_addr = 16'h0001;
    tick();
    Dc_mem_addr = 16'h0002;
    for (int k = 1; k <= 10; k++) begin
      if (k == 6) Dc_mem_req = 1'b0;
      check("b2b valid", {127'd0, MEM_mem_valid}, {127'd0, (k == 4 || k == 9)});
      check("b2b busy", {127'd0, Dm_busy}, {127'd0, (k != 5 && k != 10)});
      if (k == 4) check("b2b data1", MEM_data_line, 128'h0101_0101);
      if (k == 9) check("b2b data2", MEM_data_line, 128'h0202_0202);
      tick();
    end

    // Reset mid-read; write-back during reset must be dropped.
    pulse_reset();
    Dc_mem_req = 1'b1; Dc_mem_addr = 16'h0010;
    tick();
    Dc_mem_req = 1'b0;
    tick();
    rst = 1'b1; Dc_wb_we = 1'b1; Dc_wb_addr = 16'h0010; Dc_wb_wline = 128'hDEAD;
    tick();
    rst = 1'b0; Dc_wb_we = 1'b0;
    for (int k = 3; k <= 10; k++) begin
      check("abort valid", {127'd0, MEM_mem_valid}, 128'd0);
      check("abort rd_cnt", {96'd0, Dm_rd_cnt}, 128'd0);
      check("abort wb_cnt", {96'd0, Dm_wb_cnt}, 128'd0);
      tick();
    end
    read_line(16'h0010, LIT1, "post_reset");

    // Aliasing of upper index bits.
    wb(16'h1005, 128'hCAFE_F00D);
    read_line(16'h0005, 128'hCAFE_F00D, "alias");

    // Two write-backs to one line: last one kept.
    wb(16'h0040, 128'h1111);
    wb(16'h0040, 128'h2222);
    read_line(16'h0040, 128'h2222, "last_wb");

    // Write-back coinciding with acceptance: both take effect.
    wb(16'h0050, 128'h5050);
    tick();
    Dc_mem_req = 1'b1; Dc_mem_addr = 16'h0050;
    Dc_wb_we = 1'b1; Dc_wb_addr = 16'h0060; Dc_wb_wline = 128'h6060;
    tick();
    Dc_mem_req = 1'b0; Dc_wb_we = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      check("coincide valid", {127'd0, MEM_mem_valid}, {127'd0, (k == 4)});
      if (k == 4) check("coincide data", MEM_data_line, 128'h5050);
      tick();
    end
    read_line(16'h0060, 128'h6060, "coincide_wb");

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
